// File: rtl/ulpi_link_ctrl.sv
// ULPI link-side controller: register read/write transactions toward the PHY
// plus RX CMD / RX data capture whenever the PHY owns the bus.
module ulpi_link_ctrl #(
    parameter int NXT_TIMEOUT = 255
) (
    input  logic       ulpi_clk,
    input  logic       ulpi_reset,
    input  logic [7:0] ulpi_data_read,
    output logic [7:0] ulpi_data_write,
    output logic [7:0] ulpi_data_writeEnable,
    input  logic       ulpi_direction,
    input  logic       ulpi_nxt,
    output logic       ulpi_stp,
    input  logic       reg_req_valid,
    output logic       reg_req_ready,
    input  logic       reg_req_write,
    input  logic [5:0] reg_req_addr,
    input  logic [7:0] reg_req_wdata,
    output logic       reg_rsp_valid,
    output logic [7:0] reg_rsp_rdata,
    output logic       reg_rsp_aborted,
    output logic       rx_cmd_valid,
    output logic [7:0] rx_cmd,
    output logic       rx_data_valid,
    output logic [7:0] rx_data,
    output logic [1:0] linestate
);

    localparam int CW = (NXT_TIMEOUT > 255) ? $clog2(NXT_TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {
        IDLE, TX_CMD, TX_DATA, TX_STP, RD_TURN, RD_DATA
    } state_e;

    state_e        state_q, state_d;
    logic          dir_d1_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_write_q, req_write_d;
    logic [5:0]    req_addr_q, req_addr_d;
    logic [7:0]    req_wdata_q, req_wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          rsp_aborted_q, rsp_aborted_d;
    logic          rx_cmd_valid_q, rx_cmd_valid_d;
    logic [7:0]    rx_cmd_q, rx_cmd_d;
    logic          rx_data_valid_q, rx_data_valid_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic [1:0]    linestate_q, linestate_d;

    logic req_accept;
    logic tmo_hit;
    logic tx_wait;
    logic rx_active;

    // Accept only on a link-owned, non-turnaround cycle, and never during the response pulse.
    assign req_accept = (state_q == IDLE) && reg_req_valid && !ulpi_direction && !dir_d1_q
                        && !rsp_valid_q && !ulpi_reset;
    assign tx_wait    = (state_q == TX_CMD) || (state_q == TX_DATA);
    assign tmo_hit    = !ulpi_nxt && ((32'(cnt_q) + 32'd1) >= 32'(NXT_TIMEOUT));
    // PHY-owned cycle that is not consumed as read data by RD_DATA.
    assign rx_active  = ulpi_direction && dir_d1_q && ((state_q != RD_DATA) || ulpi_nxt);

    always_ff @(posedge ulpi_clk) begin
        if (ulpi_reset) begin
            state_q         <= IDLE;
            dir_d1_q        <= 1'b1;
            cnt_q           <= '0;
            req_write_q     <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_aborted_q   <= 1'b0;
            rx_cmd_valid_q  <= 1'b0;
            rx_cmd_q        <= '0;
            rx_data_valid_q <= 1'b0;
            rx_data_q       <= '0;
            linestate_q     <= '0;
        end else begin
            state_q         <= state_d;
            dir_d1_q        <= ulpi_direction;
            cnt_q           <= cnt_d;
            req_write_q     <= req_write_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_aborted_q   <= rsp_aborted_d;
            rx_cmd_valid_q  <= rx_cmd_valid_d;
            rx_cmd_q        <= rx_cmd_d;
            rx_data_valid_q <= rx_data_valid_d;
            rx_data_q       <= rx_data_d;
            linestate_q     <= linestate_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_write_d   = req_write_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_aborted_d = rsp_aborted_q;

        case (state_q)
            IDLE: begin
                if (req_accept) begin
                    req_write_d = reg_req_write;
                    req_addr_d  = reg_req_addr;
                    req_wdata_d = reg_req_wdata;
                    state_d     = TX_CMD;
                end
            end
            TX_CMD, TX_DATA: begin
                if (ulpi_direction || (!ulpi_nxt && tmo_hit)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_aborted_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = IDLE;
                end else if (ulpi_nxt) begin
                    if (state_q == TX_DATA)  state_d = TX_STP;
                    else if (req_write_q)    state_d = TX_DATA;
                    else                     state_d = RD_TURN;
                end
            end
            TX_STP: begin
                rsp_valid_d   = 1'b1;
                rsp_aborted_d = 1'b0;
                rsp_rdata_d   = '0;
                state_d       = IDLE;
            end
            RD_TURN: begin
                if (ulpi_direction) begin
                    state_d = RD_DATA;
                end else begin
                    rsp_valid_d   = 1'b1;
                    rsp_aborted_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = IDLE;
                end
            end
            RD_DATA: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
                if (ulpi_direction && !ulpi_nxt) begin
                    rsp_aborted_d = 1'b0;
                    rsp_rdata_d   = ulpi_data_read;
                end else begin
                    rsp_aborted_d = 1'b1;
                    rsp_rdata_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q;
        if ((state_d == TX_CMD || state_d == TX_DATA) && (state_d != state_q))
            cnt_d = '0;
        else if (tx_wait && !ulpi_nxt && (cnt_q != {CW{1'b1}}))
            cnt_d = cnt_q + 1'b1;

        rx_cmd_valid_d  = rx_active && !ulpi_nxt;
        rx_data_valid_d = rx_active && ulpi_nxt;
        rx_cmd_d        = rx_cmd_valid_d  ? ulpi_data_read      : rx_cmd_q;
        rx_data_d       = rx_data_valid_d ? ulpi_data_read      : rx_data_q;
        linestate_d     = rx_cmd_valid_d  ? ulpi_data_read[1:0] : linestate_q;
    end

    always_comb begin
        ulpi_data_writeEnable = (!ulpi_direction && !dir_d1_q) ? 8'hFF : 8'h00;
        ulpi_stp              = (state_q == TX_STP);
        reg_req_ready         = req_accept;
        case (state_q)
            TX_CMD:  ulpi_data_write = {(req_write_q ? 2'b10 : 2'b11), req_addr_q};
            TX_DATA: ulpi_data_write = req_wdata_q;
            default: ulpi_data_write = 8'h00;
        endcase
    end

    assign reg_rsp_valid   = rsp_valid_q;
    assign reg_rsp_rdata   = rsp_rdata_q;
    assign reg_rsp_aborted = rsp_aborted_q;
    assign rx_cmd_valid    = rx_cmd_valid_q;
    assign rx_cmd          = rx_cmd_q;
    assign rx_data_valid   = rx_data_valid_q;
    assign rx_data         = rx_data_q;
    assign linestate       = linestate_q;

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// Directed bench for ulpi_link_ctrl: register write/read, aborts, timeout,
// RX CMD/data capture and mid-transaction reset.
module tb_ulpi_link_ctrl;

    logic       ulpi_clk = 1'b0;
    logic       ulpi_reset;
    logic [7:0] ulpi_data_read;
    logic [7:0] ulpi_data_write;
    logic [7:0] ulpi_data_writeEnable;
    logic       ulpi_direction;
    logic       ulpi_nxt;
    logic       ulpi_stp;
    logic       reg_req_valid;
    logic       reg_req_ready;
    logic       reg_req_write;
    logic [5:0] reg_req_addr;
    logic [7:0] reg_req_wdata;
    logic       reg_rsp_valid;
    logic [7:0] reg_rsp_rdata;
    logic       reg_rsp_aborted;
    logic       rx_cmd_valid;
    logic [7:0] rx_cmd;
    logic       rx_data_valid;
    logic [7:0] rx_data;
    logic [1:0] linestate;

    int n_chk = 0;
    int n_err = 0;

    ulpi_link_ctrl #(.NXT_TIMEOUT(255)) dut (
        .ulpi_clk              (ulpi_clk),
        .ulpi_reset            (ulpi_reset),
        .ulpi_data_read        (ulpi_data_read),
        .ulpi_data_write       (ulpi_data_write),
        .ulpi_data_writeEnable (ulpi_data_writeEnable),
        .ulpi_direction        (ulpi_direction),
        .ulpi_nxt              (ulpi_nxt),
        .ulpi_stp              (ulpi_stp),
        .reg_req_valid         (reg_req_valid),
        .reg_req_ready         (reg_req_ready),
        .reg_req_write         (reg_req_write),
        .reg_req_addr          (reg_req_addr),
        .reg_req_wdata         (reg_req_wdata),
        .reg_rsp_valid         (reg_rsp_valid),
        .reg_rsp_rdata         (reg_rsp_rdata),
        .reg_rsp_aborted       (reg_rsp_aborted),
        .rx_cmd_valid          (rx_cmd_valid),
        .rx_cmd                (rx_cmd),
        .rx_data_valid         (rx_data_valid),
        .rx_data               (rx_data),
        .linestate             (linestate)
    );

    always #5 ulpi_clk = ~ulpi_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then stable.
    task automatic tick;
        @(posedge ulpi_clk);
        #2;
    endtask

    task automatic req(input logic wr, input logic [5:0] a, input logic [7:0] d);
        reg_req_valid = 1'b1;
        reg_req_write = wr;
        reg_req_addr  = a;
        reg_req_wdata = d;
    endtask

    initial begin
        int  w;
        logic stp_seen;
        logic rsp_seen;

        ulpi_reset = 1'b1; ulpi_data_read = 8'h00; ulpi_direction = 1'b0; ulpi_nxt = 1'b0;
        reg_req_valid = 1'b0; reg_req_write = 1'b0; reg_req_addr = '0; reg_req_wdata = '0;
        repeat (3) tick;

        // Reset state
        chk("rst_data_write", ulpi_data_write, 8'h00);
        chk("rst_stp", ulpi_stp, 1'b0);
        chk("rst_we_dir_d1", ulpi_data_writeEnable, 8'h00);
        chk("rst_rsp", {reg_rsp_valid, reg_rsp_aborted, reg_rsp_rdata}, 10'h000);
        chk("rst_rx", {rx_cmd_valid, rx_data_valid, rx_cmd, rx_data, linestate}, 20'h0);
        req(1'b1, 6'h04, 8'h45);
        #1 chk("rst_ready", reg_req_ready, 1'b0);
        reg_req_valid = 1'b0;
        ulpi_reset = 1'b0;
        tick;
        chk("we_link_owns", ulpi_data_writeEnable, 8'hFF);

        // Register write 0x04 <= 0x45
        req(1'b1, 6'h04, 8'h45);
        #1 chk("wr_ready", reg_req_ready, 1'b1);
        tick; reg_req_valid = 1'b0;
        #1 chk("wr_cmd_byte", ulpi_data_write, 8'h84);
        chk("wr_ready_busy", reg_req_ready, 1'b0);
        tick; ulpi_nxt = 1'b1;
        chk("wr_cmd_hold", ulpi_data_write, 8'h84);
        tick; ulpi_nxt = 1'b0;
        chk("wr_data_byte", ulpi_data_write, 8'h45);
        tick; ulpi_nxt = 1'b1;
        tick; ulpi_nxt = 1'b0;
        chk("wr_stp", ulpi_stp, 1'b1);
        chk("wr_stp_noop", ulpi_data_write, 8'h00);
        chk("wr_rsp_early", reg_rsp_valid, 1'b0);
        tick;
        chk("wr_stp_once", ulpi_stp, 1'b0);
        chk("wr_rsp", {reg_rsp_valid, reg_rsp_aborted, reg_rsp_rdata}, {2'b10, 8'h00});

        // Read 0x0A; request presented during the response pulse must wait
        req(1'b0, 6'h0A, 8'h00);
        #1 chk("rd_ready_blocked", reg_req_ready, 1'b0);
        tick;
        chk("rsp_pulse", reg_rsp_valid, 1'b0);
        #1 chk("rd_ready", reg_req_ready, 1'b1);
        tick; reg_req_valid = 1'b0;
        chk("rd_cmd_byte", ulpi_data_write, 8'hCA);
        ulpi_nxt = 1'b1;
        tick; ulpi_nxt = 1'b0; ulpi_direction = 1'b1;
        #1 chk("rd_turn_we", ulpi_data_writeEnable, 8'h00);
        chk("rd_turn_noop", ulpi_data_write, 8'h00);
        tick; ulpi_data_read = 8'h5A;
        #1 chk("rd_data_we", ulpi_data_writeEnable, 8'h00);
        tick;
        chk("rd_rsp", {reg_rsp_valid, reg_rsp_aborted, reg_rsp_rdata}, {2'b10, 8'h5A});
        chk("rd_no_rx", {rx_cmd_valid, rx_data_valid}, 2'b00);
        ulpi_direction = 1'b0;
        #1 chk("rd_we_after", ulpi_data_writeEnable, 8'h00);
        tick;
        chk("rd_we_back", ulpi_data_writeEnable, 8'hFF);

        // Write aborted by PHY taking the bus, followed by RX CMD 0x0D
        req(1'b1, 6'h05, 8'h33);
        tick; reg_req_valid = 1'b0; ulpi_direction = 1'b1;
        stp_seen = ulpi_stp;
        tick; ulpi_data_read = 8'h0D; ulpi_nxt = 1'b0;
        stp_seen = stp_seen | ulpi_stp;
        chk("ab_rsp", {reg_rsp_valid, reg_rsp_aborted, reg_rsp_rdata}, {2'b11, 8'h00});
        chk("ab_turn_no_rx", {rx_cmd_valid, rx_data_valid}, 2'b00);
        tick; ulpi_direction = 1'b0;
        stp_seen = stp_seen | ulpi_stp;
        chk("ab_rx_cmd", {rx_cmd_valid, rx_cmd}, {1'b1, 8'h0D});
        chk("ab_linestate", linestate, 2'b01);
        chk("ab_rsp_pulse", reg_rsp_valid, 1'b0);
        tick;
        chk("ab_no_stp", stp_seen | ulpi_stp, 1'b0);
        chk("ab_rx_cmd_pulse", rx_cmd_valid, 1'b0);

        // RX burst: turnaround byte ignored, then cmd 0x4C, data 0x11, 0x22
        ulpi_direction = 1'b1; ulpi_data_read = 8'hFF; ulpi_nxt = 1'b1;
        tick; ulpi_data_read = 8'h4C; ulpi_nxt = 1'b0;
        chk("rx_turn_in", {rx_cmd_valid, rx_data_valid}, 2'b00);
        tick; ulpi_data_read = 8'h11; ulpi_nxt = 1'b1;
        chk("rx_cmd", {rx_cmd_valid, rx_data_valid, rx_cmd}, {2'b10, 8'h4C});
        chk("rx_linestate", linestate, 2'b00);
        tick; ulpi_data_read = 8'h22;
        chk("rx_data0", {rx_cmd_valid, rx_data_valid, rx_data}, {2'b01, 8'h11});
        tick; ulpi_direction = 1'b0; ulpi_nxt = 1'b0; ulpi_data_read = 8'h00;
        chk("rx_data1", {rx_cmd_valid, rx_data_valid, rx_data}, {2'b01, 8'h22});
        tick;
        chk("rx_turn_out", {rx_cmd_valid, rx_data_valid}, 2'b00);

        // nxt never comes: abort after NXT_TIMEOUT cycles in TX_CMD
        req(1'b1, 6'h01, 8'hA5);
        tick; reg_req_valid = 1'b0;
        chk("to_cmd_byte", ulpi_data_write, 8'h81);
        w = 0; stp_seen = 1'b0;
        do begin
            tick; w++;
            stp_seen = stp_seen | ulpi_stp;
        end while (!reg_rsp_valid && w < 600);
        chk("to_cycles", w, 255);
        chk("to_rsp", {reg_rsp_valid, reg_rsp_aborted, reg_rsp_rdata}, {2'b11, 8'h00});
        chk("to_no_stp", stp_seen, 1'b0);
        chk("to_idle", ulpi_data_write, 8'h00);

        // Next request accepted, then dropped by reset while in TX_DATA
        req(1'b1, 6'h02, 8'h99);
        tick;
        #1 chk("to_next_ready", reg_req_ready, 1'b1);
        tick; reg_req_valid = 1'b0; ulpi_nxt = 1'b1;
        tick; ulpi_nxt = 1'b0;
        chk("mr_tx_data", ulpi_data_write, 8'h99);
        ulpi_reset = 1'b1;
        tick; ulpi_reset = 1'b0;
        chk("mr_idle", {ulpi_stp, ulpi_data_write}, 9'h000);
        rsp_seen = reg_rsp_valid; stp_seen = ulpi_stp;
        repeat (3) begin
            tick;
            rsp_seen = rsp_seen | reg_rsp_valid;
            stp_seen = stp_seen | ulpi_stp;
        end
        chk("mr_no_rsp_stp", {rsp_seen, stp_seen}, 2'b00);

        // Read aborted by nxt in RD_DATA; byte goes out as RX data
        req(1'b0, 6'h16, 8'h00);
        tick; reg_req_valid = 1'b0; ulpi_nxt = 1'b1;
        tick; ulpi_nxt = 1'b0; ulpi_direction = 1'b1;
        tick; ulpi_nxt = 1'b1; ulpi_data_read = 8'h77;
        tick; ulpi_nxt = 1'b0; ulpi_direction = 1'b0;
        chk("rda_rsp", {reg_rsp_valid, reg_rsp_aborted, reg_rsp_rdata}, {2'b11, 8'h00});
        chk("rda_rx_data", {rx_cmd_valid, rx_data_valid, rx_data}, {2'b01, 8'h77});
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ulpi_link_ctrl.md
ULPI_LINK_CTRL -- requirements
Module: ulpi_link_ctrl

Interface
REQ-001 SHALL have parameter NXT_TIMEOUT, default 255: max cycles waiting for ulpi_nxt in a TX state before abort.
REQ-002 SHALL have port ulpi_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port ulpi_reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports ulpi_data_read in 8 (PHY->link bus); ulpi_data_write out 8 (link->PHY bus); ulpi_data_writeEnable out 8 (per-bit output enable).
REQ-005 SHALL have ports ulpi_direction in 1; ulpi_nxt in 1; ulpi_stp out 1.
REQ-006 SHALL have request ports reg_req_valid in 1; reg_req_ready out 1; reg_req_write in 1 (1=write, 0=read); reg_req_addr in 6; reg_req_wdata in 8.
REQ-007 SHALL have response ports reg_rsp_valid out 1; reg_rsp_rdata out 8; reg_rsp_aborted out 1.
REQ-008 SHALL have RX ports rx_cmd_valid out 1; rx_cmd out 8; rx_data_valid out 1; rx_data out 8; linestate out 2.

Function
REQ-009 SHALL register ulpi_direction each cycle as dir_d1; a turnaround cycle is any cycle where ulpi_direction != dir_d1.
REQ-010 SHALL drive ulpi_data_writeEnable = 8'hFF when ulpi_direction=0 and dir_d1=0, else 8'h00 (combinational from ulpi_direction).
REQ-011 SHALL drive ulpi_data_write = 8'h00 (NOOP) in IDLE, RD_TURN, RD_DATA and TX_STP.
REQ-012 SHALL implement states IDLE, TX_CMD, TX_DATA, TX_STP, RD_TURN, RD_DATA.
REQ-013 IDLE: when reg_req_valid=1, ulpi_direction=0, dir_d1=0: reg_req_ready=1 for that cycle, latch write/addr/wdata, go TX_CMD; otherwise reg_req_ready=0.
REQ-014 TX_CMD: ulpi_data_write = {2'b10,addr} for write, {2'b11,addr} for read; on nxt=1 (dir=0) go TX_DATA (write) or RD_TURN (read).
REQ-015 TX_DATA: ulpi_data_write = wdata; on nxt=1 go TX_STP.
REQ-016 TX_STP: ulpi_stp=1 for exactly one cycle; next cycle reg_rsp_valid=1, aborted=0, rdata=0; state IDLE.
REQ-017 RD_TURN (one cycle): ulpi_direction=1 -> RD_DATA; ulpi_direction=0 -> abort.
REQ-018 RD_DATA: dir=1, nxt=0 -> next cycle reg_rsp_valid=1, rdata=ulpi_data_read sampled, aborted=0; dir=1, nxt=1 -> abort, byte handled as RX data; dir=0 -> abort; all go IDLE.
REQ-019 Abort: ulpi_direction=1 sampled in TX_CMD or TX_DATA, or wait counter reaching NXT_TIMEOUT in TX_CMD/TX_DATA -> next cycle reg_rsp_valid=1, aborted=1, rdata=0; IDLE; no stp.
REQ-020 Wait counter: 8+ bits, cleared on entry to TX_CMD and TX_DATA, increments each cycle nxt=0, saturates.
REQ-021 reg_rsp_valid SHALL be a single-cycle pulse; exactly one response per accepted request; no new request accepted until the response cycle has passed.
REQ-022 RX path: when ulpi_direction=1, dir_d1=1, state!=RD_DATA (or RD_DATA abort per REQ-018): nxt=0 -> rx_cmd_valid=1, rx_cmd=ulpi_data_read next cycle; nxt=1 -> rx_data_valid=1, rx_data=ulpi_data_read next cycle.
REQ-023 linestate SHALL hold rx_cmd[1:0] of the most recent RX CMD.
REQ-024 rx_cmd_valid and rx_data_valid SHALL be single-cycle pulses, never both 1; turnaround cycles produce neither.

Reset
REQ-025 With ulpi_reset=1 at a clock edge: state=IDLE, dir_d1=1, counter=0, ulpi_stp=0, ulpi_data_write=0, reg_req_ready=0, reg_rsp_valid=0, reg_rsp_aborted=0, reg_rsp_rdata=0, rx_cmd_valid=0, rx_data_valid=0, rx_cmd=0, rx_data=0, linestate=0.
REQ-026 Reset mid-transaction SHALL drop it with no response and no stp.

Verification
REQ-027 Write addr 0x04 data 0x45, nxt high 1 cycle after each of cmd/data -> bus 0x84, 0x45, stp=1 with 0x00, reg_rsp_valid aborted=0.
REQ-028 Read addr 0x0A, nxt, dir=1 turnaround, PHY drives 0x5A nxt=0 -> reg_rsp_rdata=0x5A, aborted=0; writeEnable=0x00 while dir=1 and one cycle after.
REQ-029 Write request, PHY raises dir before nxt, sends RX CMD 0x0D -> reg_rsp aborted=1, rx_cmd=0x0D, linestate=2'b01, stp never asserted.
REQ-030 nxt held 0 for NXT_TIMEOUT cycles in TX_CMD -> aborted=1 response, state IDLE, next request accepted.
REQ-031 Dir=1 RX burst: cmd 0x4C nxt=0, then 0x11, 0x22 nxt=1 -> one rx_cmd_valid, two rx_data_valid in order, no valid in turnaround cycles.
